fst_cell_gen: RTL
=================

# fst_cell_gen

- Upstream neighbour of the packet-analysis stage.
- Accepts the ingress packet beat stream and emits, per packet, only the first CELL_SZ beats as "first cells".
- Each first cell carries the cell message layout the analyser's unframer expects: SOC in msg bit 3, EOC in msg bit 2.
- Beats beyond the head are absorbed and discarded; the payload path taps the stream independently.
- Output is a one-stage registered valid/ready port honouring `fst_cell_rdy` backpressure.

## Interface
- `DWID`, 256, beat/cell data width
- `FCMWID`, 50, cell message width (minimum 32)
- `CELL_SZ`, 8, max head cells per packet (power of two, 2..16)
- `PORT_WID`, 4, ingress port id width
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_vld`  in  1  ingress beat valid
- `in_rdy`  out  1  ingress beat accepted when `in_vld && in_rdy`
- `in_dat`  in  DWID  beat data
- `in_sop`  in  1  first beat of packet
- `in_eop`  in  1  last beat of packet
- `in_mty`  in  5  empty bytes on eop beat (0..31)
- `in_port`  in  PORT_WID  ingress port, sampled on sop beat
- `fst_cell_vld`  out  1  first-cell valid
- `fst_cell_rdy`  in  1  downstream ready
- `fst_cell_dat`  out  DWID  cell data (beat data unchanged)
- `fst_cell_msg`  out  FCMWID  cell message
- `dbg_pkt_cnt`  out  32  packets started (wraps)
- `dbg_err_cnt`  out  16  framing errors (saturates at 0xFFFF)

## Operation
- Message layout:
  - [1:0] = 0
  - [2] EOC
  - [3] SOC
  - [7:4] port (zero-extended or truncated to PORT_WID)
  - [11:8] cell index
  - [12] PKT_END: this cell also carries `in_eop`
  - [17:13] mty, valid only when PKT_END is set, else 0
  - [32:18] 15-bit packet sequence number, wraps
  - higher bits = 0
- FSM `IDLE`:
  - Accepted beat with `in_sop`: emit cell with SOC=1, index 0; latch port; increment seq and `dbg_pkt_cnt`.
  - If `in_eop` is also set: EOC=1, PKT_END=1, stay in `IDLE`; otherwise go to `HEAD`.
  - Accepted beat without sop: discard, `dbg_err_cnt`+1.
- FSM `HEAD`:
  - Each accepted beat is emitted with index+1.
  - EOC=1 when `in_eop` or index==CELL_SZ-1.
  - eop → `IDLE`.
  - index==CELL_SZ-1 without eop → `DROP`.
- FSM `DROP`:
  - Beats are accepted and discarded.
  - eop → `IDLE`.
- sop arriving in `HEAD` or `DROP`:
  - `dbg_err_cnt`+1.
  - The beat is treated as a new packet exactly as in `IDLE`.
  - The previous packet stays truncated without EOC; downstream resyncs on SOC.
- `in_rdy`:
  - `IDLE`/`HEAD`: `!fst_cell_vld || fst_cell_rdy`.
  - `DROP`: 1 unless `in_sop` is asserted, in which case it uses the `IDLE` rule.
  - 0 while `rst` is asserted.

## Timing
- Reset (async assert, sync release): state `IDLE`, index 0, seq 0, counters 0, `fst_cell_vld`=0, `fst_cell_dat`=0, `fst_cell_msg`=0.
- Latency: cell appears on the cycle after the accepting beat.
- Throughput: one cell per cycle when `fst_cell_rdy`=1.
- Output holds dat/msg stable while `fst_cell_vld && !fst_cell_rdy`.
- The output register reloads on the same cycle it drains (accept and drain simultaneous → no bubble).
- No combinational path from `in_vld` to `in_rdy`. `fst_cell_rdy` to `in_rdy` is combinational.
- Reset mid-packet aborts the cell in flight; the next packet starts at seq 0.

## Structure
- Shared package `toe_cell_pkg`: message bit positions (EOC=2, SOC=3, PORT_LSB=4, IDX_LSB=8, PEND=12, MTY_LSB=13, SEQ_LSB=18), FSM enum `{IDLE, HEAD, DROP}`, cell-message packing function.
- The same package constants are used by the analyser's unframer, so both ends agree on the layout.
- Natural sub-module: `cell_out_reg`, the one-stage valid/ready output register.

## Test plan
- 3-beat packet, `in_mty`=7, port 5, rdy=1:
  - cells idx 0,1,2; SOC on idx 0 only; EOC and PKT_END on idx 2; msg[17:13]=7; msg[7:4]=5; seq 0.
- 20-beat packet, CELL_SZ=8:
  - 8 cells, EOC on idx 7, PKT_END=0.
  - Remaining 12 beats accepted with `in_rdy`=1, no output.
  - `dbg_pkt_cnt`=1.
- Single-beat packet (sop & eop) back-to-back ×4:
  - 4 cells each with SOC=EOC=PKT_END=1; seq 0..3; one cell per cycle.
- `fst_cell_rdy` low for 5 cycles mid-head:
  - output held stable; `in_rdy`=0; no beat lost or duplicated after release.
- sop at HEAD idx 2, then a 2-beat packet:
  - `dbg_err_cnt`=1; new cell has SOC=1, idx 0, seq+1.
  - A stray non-sop beat in `IDLE` raises `dbg_err_cnt` to 2.
- `rst` low during HEAD with `fst_cell_vld`=1:
  - `fst_cell_vld` drops immediately; after release the next packet is seq 0, idx 0.

Source files
------------

// File: rtl/toe_cell_pkg.sv
// Cell message layout shared by the first-cell generator and the analyser's unframer.
// Both ends import these positions so they agree on where every field lives.
package toe_cell_pkg;

    localparam int unsigned MSG_EOC      = 2;
    localparam int unsigned MSG_SOC      = 3;
    localparam int unsigned MSG_PORT_LSB = 4;
    localparam int unsigned MSG_IDX_LSB  = 8;
    localparam int unsigned MSG_PEND     = 12;
    localparam int unsigned MSG_MTY_LSB  = 13;
    localparam int unsigned MSG_SEQ_LSB  = 18;
    localparam int unsigned SEQ_W        = 15;
    localparam int unsigned MSG_USED_W   = MSG_SEQ_LSB + SEQ_W;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        DROP
    } fsm_state_t;

    // mty is only meaningful on the cell that closes the packet
    function automatic logic [MSG_USED_W-1:0] pack_cell_msg(
        input logic             soc,
        input logic             eoc,
        input logic [3:0]       port,
        input logic [3:0]       idx,
        input logic             pend,
        input logic [4:0]       mty,
        input logic [SEQ_W-1:0] seq
    );
        logic [MSG_USED_W-1:0] m;
        m                          = '0;
        m[MSG_EOC]                 = eoc;
        m[MSG_SOC]                 = soc;
        m[MSG_PORT_LSB +: 4]       = port;
        m[MSG_IDX_LSB +: 4]        = idx;
        m[MSG_PEND]                = pend;
        m[MSG_MTY_LSB +: 5]        = pend ? mty : 5'd0;
        m[MSG_SEQ_LSB +: SEQ_W]    = seq;
        return m;
    endfunction

endpackage

// File: rtl/fst_cell_gen_cell_out_reg.sv
// One-stage valid/ready output register; reloads on the same cycle it drains.
module cell_out_reg #(
    parameter int unsigned DWID = 256,
    parameter int unsigned MWID = 50
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [DWID-1:0] load_dat,
    input  logic [MWID-1:0] load_msg,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [DWID-1:0] out_dat,
    output logic [MWID-1:0] out_msg
);

    logic            vld_q, vld_d;
    logic [DWID-1:0] dat_q, dat_d;
    logic [MWID-1:0] msg_q, msg_d;

    always_comb begin
        vld_d = vld_q && !out_rdy;
        dat_d = dat_q;
        msg_d = msg_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = load_dat;
            msg_d = load_msg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            msg_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            msg_q <= msg_d;
        end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;
    assign out_msg = msg_q;

endmodule

// File: rtl/fst_cell_gen.sv
// Emits the first CELL_SZ beats of every ingress packet as framed "first cells";
// remaining beats are absorbed so the payload tap never sees backpressure from here.
module fst_cell_gen
    import toe_cell_pkg::*;
#(
    parameter int unsigned DWID     = 256,
    parameter int unsigned FCMWID   = 50,
    parameter int unsigned CELL_SZ  = 8,
    parameter int unsigned PORT_WID = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [DWID-1:0]     in_dat,
    input  logic                in_sop,
    input  logic                in_eop,
    input  logic [4:0]          in_mty,
    input  logic [PORT_WID-1:0] in_port,
    output logic                fst_cell_vld,
    input  logic                fst_cell_rdy,
    output logic [DWID-1:0]     fst_cell_dat,
    output logic [FCMWID-1:0]   fst_cell_msg,
    output logic [31:0]         dbg_pkt_cnt,
    output logic [15:0]         dbg_err_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(CELL_SZ - 1);

    fsm_state_t       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] pkt_seq_q, pkt_seq_d;
    logic [3:0]       port_q, port_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic             out_room;
    logic             accept;
    logic             load;
    logic             cell_soc, cell_eoc, cell_pend;
    logic [3:0]       cell_idx;
    logic [3:0]       cell_port;
    logic [SEQ_W-1:0] cell_seq;
    logic [3:0]       port_in4;
    logic [MSG_USED_W-1:0] cell_msg_raw;
    logic [FCMWID-1:0]     cell_msg;

    generate
        if (PORT_WID >= 4) begin : g_port_trunc
            assign port_in4 = in_port[3:0];
        end else begin : g_port_ext
            assign port_in4 = {{(4 - PORT_WID){1'b0}}, in_port};
        end

        if (FCMWID > MSG_USED_W) begin : g_msg_ext
            assign cell_msg = {{(FCMWID - MSG_USED_W){1'b0}}, cell_msg_raw};
        end else if (FCMWID == MSG_USED_W) begin : g_msg_exact
            assign cell_msg = cell_msg_raw;
        end else begin : g_msg_trunc
            assign cell_msg = cell_msg_raw[FCMWID-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            seq_q     <= '0;
            pkt_seq_q <= '0;
            port_q    <= '0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            pkt_seq_q <= pkt_seq_d;
            port_q    <= port_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Handshake and cell framing; DROP only needs output room when a new sop must be emitted
    always_comb begin
        out_room  = !fst_cell_vld || fst_cell_rdy;
        in_rdy    = 1'b0;
        if (rst) begin
            if (state_q == DROP && !in_sop) in_rdy = 1'b1;
            else                            in_rdy = out_room;
        end
        accept    = in_vld && in_rdy;
        load      = 1'b0;
        cell_soc  = 1'b0;
        cell_eoc  = 1'b0;
        cell_pend = 1'b0;
        cell_idx  = idx_q + 4'd1;
        cell_port = port_q;
        cell_seq  = pkt_seq_q;
        if (accept) begin
            if (in_sop) begin
                load      = 1'b1;
                cell_soc  = 1'b1;
                cell_eoc  = in_eop;
                cell_pend = in_eop;
                cell_idx  = '0;
                cell_port = port_in4;
                cell_seq  = seq_q;
            end else if (state_q == HEAD) begin
                load      = 1'b1;
                cell_eoc  = in_eop || (cell_idx == LAST_IDX);
                cell_pend = in_eop;
            end
        end
        cell_msg_raw = pack_cell_msg(cell_soc, cell_eoc, cell_port, cell_idx,
                                     cell_pend, in_mty, cell_seq);
    end

    always_comb begin
        logic err_inc;
        err_inc   = 1'b0;
        state_d   = state_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        pkt_seq_d = pkt_seq_q;
        port_d    = port_q;
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            if (in_sop) begin
                // sop mid-packet restarts framing; the old packet is left without EOC
                err_inc   = (state_q != IDLE);
                seq_d     = seq_q + 1'b1;
                pkt_seq_d = seq_q;
                port_d    = port_in4;
                idx_d     = '0;
                pkt_cnt_d = pkt_cnt_q + 32'd1;
                state_d   = in_eop ? IDLE : HEAD;
            end else begin
                case (state_q)
                    IDLE: err_inc = 1'b1;
                    HEAD: begin
                        idx_d = cell_idx;
                        if (in_eop)                    state_d = IDLE;
                        else if (cell_idx == LAST_IDX) state_d = DROP;
                    end
                    DROP: if (in_eop) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
        if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
    end

    cell_out_reg #(
        .DWID (DWID),
        .MWID (FCMWID)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst),
        .load     (load),
        .load_dat (in_dat),
        .load_msg (cell_msg),
        .out_vld  (fst_cell_vld),
        .out_rdy  (fst_cell_rdy),
        .out_dat  (fst_cell_dat),
        .out_msg  (fst_cell_msg)
    );

    assign dbg_pkt_cnt = pkt_cnt_q;
    assign dbg_err_cnt = err_cnt_q;

endmodule
